// File: rtl/stall_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stall_flush_ctrl
//  Description : Pipeline stall/flush controller. Merges level stall requests,
//                a data-hazard bubble request and a timed hold into one stall
//                vector. Also provides a one-cycle flush FSM state, a
//                registered flush pulse and a sticky stall-deadlock watchdog.
//  Ports       : clk, rst (async, active-high)
//                stall_req[NUM_REQ]  - level stall requests
//                bubble_req          - bubble request (lowest priority)
//                hold_start/hold_len - start a hold of hold_len cycles
//                flush               - flush request
//                stall[NUM_STAGES]   - combinational stall vector (bit 0 = PC)
//                flush_o             - flush delayed by one cycle
//                hold_busy           - FSM is in HOLD
//                deadlock            - sticky watchdog flag
//  Revision    : 1.0 - initial release
// ============================================================================
module stall_flush_ctrl #(
  parameter int                     NUM_STAGES   = 13,
  parameter int                     NUM_REQ      = 3,
  parameter logic [4*NUM_REQ-1:0]   REQ_STAGE    = 12'h123,
  parameter int                     BUBBLE_STAGE = 3,
  parameter int                     HOLD_STAGE   = 3,
  parameter int                     CNT_W        = 4,
  parameter int                     WDOG_LIMIT   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    stall_req,
  input  logic                  bubble_req,
  input  logic                  hold_start,
  input  logic [CNT_W-1:0]      hold_len,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush_o,
  output logic                  hold_busy,
  output logic                  deadlock
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam int RUN_W = $clog2(WDOG_LIMIT + 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      hold_cnt;
  logic [RUN_W-1:0]      run_cnt;
  logic [RUN_W-1:0]      run_next;
  logic [NUM_STAGES-1:0] req_stall;

  // Bits 0..k set: a request at stage k freezes everything upstream of it.
  function automatic logic [NUM_STAGES-1:0] mask(input logic [3:0] k);
    logic [NUM_STAGES-1:0] m;
    for (int i = 0; i < NUM_STAGES; i++) begin
      m[i] = (i <= int'(k));
    end
    return m;
  endfunction

  // Masks are nested, so the OR is simply the widest active request.
  always_comb begin
    req_stall = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stall_req[i]) begin
        req_stall = req_stall | mask(REQ_STAGE[4*i +: 4]);
      end
    end
    if (state == S_HOLD) begin
      req_stall = req_stall | mask(4'(HOLD_STAGE));
    end
  end

  // Flush beats everything; the bubble only fills in when nothing else stalls.
  always_comb begin
    stall = '0;
    if (rst || flush || (state == S_FLUSH)) begin
      stall = '0;
    end else if (|req_stall) begin
      stall = req_stall;
    end else if (bubble_req) begin
      stall[BUBBLE_STAGE] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
    end else if (flush) begin
      state    <= S_FLUSH;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hold_start && (hold_len != '0)) begin
            state    <= S_HOLD;
            hold_cnt <= hold_len;
          end
        end
        S_HOLD: begin
          // Leaving on the count of 1 makes the hold last exactly hold_len cycles.
          if (hold_cnt == CNT_W'(1)) begin
            state <= S_IDLE;
          end
          hold_cnt <= hold_cnt - CNT_W'(1);
        end
        S_FLUSH: begin
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign hold_busy = (state == S_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_o <= 1'b0;
    end else begin
      flush_o <= flush;
    end
  end

  // Watchdog counts consecutive cycles with the PC frozen, saturating.
  always_comb begin
    run_next = '0;
    if (flush) begin
      run_next = '0;
    end else if (stall[0]) begin
      run_next = (run_cnt == RUN_W'(WDOG_LIMIT)) ? run_cnt : run_cnt + RUN_W'(1);
    end else begin
      run_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt  <= '0;
      deadlock <= 1'b0;
    end else begin
      run_cnt  <= run_next;
      deadlock <= flush ? 1'b0 : (deadlock | (run_next == RUN_W'(WDOG_LIMIT)));
    end
  end

endmodule
`default_nettype wire
